// File: rtl/fifo_scoreboard_checker.sv
// fifo_scoreboard_checker: snoops a sync FIFO port bundle,
// shadows it with a reference model and scores every cycle.
module fifo_scoreboard_checker #(
  parameter int         DATA_WIDTH = 16,
  parameter int         FIFO_DEPTH = 8,
  parameter int         CNT_WIDTH  = 16,
  parameter logic [7:0] CHECK_MASK = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  finish,
  input  logic                  mon_rst_n,
  input  logic                  mon_wr_en,
  input  logic                  mon_rd_en,
  input  logic [DATA_WIDTH-1:0] mon_data_in,
  input  logic [DATA_WIDTH-1:0] mon_data_out,
  input  logic [7:0]            mon_status,
  output logic                  check_valid,
  output logic                  check_pass,
  output logic [CNT_WIDTH-1:0]  pass_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [7:0]            err_flags,
  output logic                  first_err_vld,
  output logic [7:0]            first_err_map,
  output logic [CNT_WIDTH-1:0]  first_err_cyc,
  output logic                  report_valid
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] L_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] L_AFULL = (AW+1)'(FIFO_DEPTH - 1);
  localparam logic [AW:0] L_ONE   = (AW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CHECK,
    S_FROZEN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [AW:0]           r_count;
  logic [DATA_WIDTH-1:0] r_exp_dout;
  logic                  r_exp_ack;
  logic                  r_exp_ovf;
  logic                  r_exp_udf;
  logic                  r_prev_rd;
  logic                  r_first;

  logic                 r_valid;
  logic                 r_pass;
  logic [CNT_WIDTH-1:0] r_pass_cnt;
  logic [CNT_WIDTH-1:0] r_err_cnt;
  logic [7:0]           r_flags;
  logic                 r_fvld;
  logic [7:0]           r_fmap;
  logic [CNT_WIDTH-1:0] r_fcyc;
  logic [CNT_WIDTH-1:0] r_cyc;

  logic       w_full;
  logic       w_afull;
  logic       w_empty;
  logic       w_aempty;
  logic       w_upd;
  logic       w_clr;
  logic       w_wr_ok;
  logic       w_rd_ok;
  logic       w_cmp;
  logic [7:0] w_exp;
  logic [7:0] w_diff;
  logic [7:0] w_mm;
  logic       w_unused;

  assign w_unused = mon_status[0];

  assign w_full   = (r_count == L_FULL);
  assign w_afull  = (r_count == L_AFULL);
  assign w_empty  = (r_count == '0);
  assign w_aempty = (r_count == L_ONE);

  assign w_upd   = (r_state == S_CHECK) && mon_rst_n;
  assign w_clr   = !mon_rst_n && (r_state != S_FROZEN);
  assign w_wr_ok = mon_wr_en && !w_full;
  assign w_rd_ok = mon_rd_en && !w_empty;

  assign w_exp = {r_exp_ack, r_exp_udf, r_exp_ovf, w_aempty,
                  w_empty, w_afull, w_full, 1'b0};
  assign w_diff[7:1] = mon_status[7:1] ^ w_exp[7:1];
  assign w_diff[0]   = r_prev_rd && (mon_data_out != r_exp_dout);
  assign w_mm  = w_diff & CHECK_MASK;
  assign w_cmp = w_upd && !r_first;

  // next-state: finish wins from any live state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (finish)      w_next = S_FROZEN;
        else if (enable) w_next = S_ARMED;
      end
      S_ARMED: begin
        if (finish)         w_next = S_FROZEN;
        else if (mon_rst_n) w_next = S_CHECK;
      end
      S_CHECK: begin
        if (finish)          w_next = S_FROZEN;
        else if (!mon_rst_n) w_next = S_ARMED;
      end
      S_FROZEN: w_next = S_FROZEN;
      default:  w_next = S_IDLE;
    endcase
  end

  // state register and first-checking-cycle marker
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_first <= 1'b1;
    end else begin
      r_state <= w_next;
      r_first <= (r_state != S_CHECK);
    end
  end

  // shadow storage, written only on accepted writes
  always_ff @(posedge clk) begin
    if (w_upd && w_wr_ok) r_mem[r_wptr] <= mon_data_in;
  end

  // shadow pointers, occupancy and registered FIFO outputs
  always_ff @(posedge clk) begin
    if (rst || w_clr) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_exp_dout <= '0;
      r_exp_ack  <= 1'b0;
      r_exp_ovf  <= 1'b0;
      r_exp_udf  <= 1'b0;
      r_prev_rd  <= 1'b0;
    end else if (w_upd) begin
      if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
      if (w_rd_ok) begin
        r_rptr     <= r_rptr + 1'b1;
        r_exp_dout <= r_mem[r_rptr];
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_exp_ack <= w_wr_ok;
      r_exp_ovf <= mon_wr_en && w_full;
      r_exp_udf <= mon_rd_en && w_empty;
      r_prev_rd <= w_rd_ok;
    end
  end

  // registered scoring; everything holds once frozen
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_pass     <= 1'b0;
      r_pass_cnt <= '0;
      r_err_cnt  <= '0;
      r_flags    <= '0;
      r_fvld     <= 1'b0;
      r_fmap     <= '0;
      r_fcyc     <= '0;
      r_cyc      <= '0;
    end else if (r_state != S_FROZEN) begin
      r_valid <= w_cmp;
      r_pass  <= w_cmp && (w_mm == '0);
      if ((r_state == S_CHECK) && (r_cyc != '1))
        r_cyc <= r_cyc + 1'b1;
      if (w_cmp) begin
        if (w_mm == '0) begin
          if (r_pass_cnt != '1) r_pass_cnt <= r_pass_cnt + 1'b1;
        end else begin
          if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
          r_flags <= r_flags | w_mm;
          if (!r_fvld) begin
            r_fvld <= 1'b1;
            r_fmap <= w_mm;
            r_fcyc <= r_cyc;
          end
        end
      end
    end
  end

  assign check_valid   = r_valid;
  assign check_pass    = r_pass;
  assign pass_cnt      = r_pass_cnt;
  assign err_cnt       = r_err_cnt;
  assign err_flags     = r_flags;
  assign first_err_vld = r_fvld;
  assign first_err_map = r_fmap;
  assign first_err_cyc = r_fcyc;
  assign report_valid  = (r_state == S_FROZEN);

endmodule

// File: tb/tb_fifo_scoreboard_checker.sv
// tb_fifo_scoreboard_checker: two checker instances driven by a
// queue-based FIFO with injected faults, scored against a model.
module tb_fifo_scoreboard_checker;

  logic        clk = 1'b0;
  logic        rst, enable, finish;
  logic        mon_rst_n, mon_wr_en, mon_rd_en;
  logic [15:0] mon_data_in, mon_data_out;
  logic [7:0]  mon_status;

  logic        a_cv, a_cp, a_fvld, a_rv;
  logic [15:0] a_pc, a_ec, a_fcyc;
  logic [7:0]  a_fl, a_fmap;
  logic        b_cv, b_cp, b_fvld, b_rv;
  logic [3:0]  b_pc, b_ec, b_fcyc;
  logic [7:0]  b_fl, b_fmap;

  always #5 clk = ~clk;

  fifo_scoreboard_checker #(
    .DATA_WIDTH(16), .FIFO_DEPTH(8),
    .CNT_WIDTH(16), .CHECK_MASK(8'hFF)
  ) u_a (
    .clk(clk), .rst(rst), .enable(enable), .finish(finish),
    .mon_rst_n(mon_rst_n), .mon_wr_en(mon_wr_en),
    .mon_rd_en(mon_rd_en), .mon_data_in(mon_data_in),
    .mon_data_out(mon_data_out), .mon_status(mon_status),
    .check_valid(a_cv), .check_pass(a_cp),
    .pass_cnt(a_pc), .err_cnt(a_ec), .err_flags(a_fl),
    .first_err_vld(a_fvld), .first_err_map(a_fmap),
    .first_err_cyc(a_fcyc), .report_valid(a_rv)
  );

  fifo_scoreboard_checker #(
    .DATA_WIDTH(16), .FIFO_DEPTH(8),
    .CNT_WIDTH(4), .CHECK_MASK(8'hFE)
  ) u_b (
    .clk(clk), .rst(rst), .enable(enable), .finish(finish),
    .mon_rst_n(mon_rst_n), .mon_wr_en(mon_wr_en),
    .mon_rd_en(mon_rd_en), .mon_data_in(mon_data_in),
    .mon_data_out(mon_data_out), .mon_status(mon_status),
    .check_valid(b_cv), .check_pass(b_cp),
    .pass_cnt(b_pc), .err_cnt(b_ec), .err_flags(b_fl),
    .first_err_vld(b_fvld), .first_err_map(b_fmap),
    .first_err_cyc(b_fcyc), .report_valid(b_rv)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] din;
    logic [7:0]  flip;
    logic        exp_pass;
  } vec_t;

  vec_t tbl[$];

  int n_chk  = 0;
  int n_fail = 0;

  // behavioural FIFO driven onto the monitor bundle
  logic [15:0] q[$];
  logic [15:0] f_dout;
  logic        f_ack, f_ovf, f_udf;
  logic        prev_rdok;

  // scoreboard-level expectation
  bit live, frozen;
  int hi_prev, cyc;
  int e_cv[2], e_cp[2], e_pass[2], e_err[2];
  int e_flags[2], e_fvld[2], e_fmap[2], e_fcyc[2];
  int max_c[2] = '{65535, 15};
  logic [7:0] msk[2] = '{8'hFF, 8'hFE};

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic clear_exp();
    live = 0; frozen = 0; hi_prev = 0; cyc = 0;
    for (int i = 0; i < 2; i++) begin
      e_cv[i] = 0; e_cp[i] = 0; e_pass[i] = 0; e_err[i] = 0;
      e_flags[i] = 0; e_fvld[i] = 0; e_fmap[i] = 0; e_fcyc[i] = 0;
    end
  endtask

  task automatic check_all();
    chk("a_valid", a_cv, e_cv[0]);
    chk("a_pass", a_cp, e_cp[0]);
    chk("a_pass_cnt", a_pc, e_pass[0]);
    chk("a_err_cnt", a_ec, e_err[0]);
    chk("a_err_flags", a_fl, e_flags[0]);
    chk("a_first_vld", a_fvld, e_fvld[0]);
    chk("a_first_map", a_fmap, e_fmap[0]);
    chk("a_first_cyc", a_fcyc, e_fcyc[0]);
    chk("a_report", a_rv, frozen);
    chk("b_valid", b_cv, e_cv[1]);
    chk("b_pass", b_cp, e_cp[1]);
    chk("b_pass_cnt", b_pc, e_pass[1]);
    chk("b_err_cnt", b_ec, e_err[1]);
    chk("b_err_flags", b_fl, e_flags[1]);
    chk("b_first_vld", b_fvld, e_fvld[1]);
    chk("b_first_map", b_fmap, e_fmap[1]);
    chk("b_first_cyc", b_fcyc, e_fcyc[1]);
    chk("b_report", b_rv, frozen);
  endtask

  task automatic step(input logic r, en, fin, rn, wr, rd,
                      input logic [15:0] din, input logic [7:0] flip);
    logic wg, rg, wok, rok, cmp, cc;
    logic [7:0] map, mm;
    int sz;
    sz = q.size();
    wg = wr && live && (hi_prev >= 1) && !r;
    rg = rd && live && (hi_prev >= 1) && !r;
    rst = r; enable = en; finish = fin; mon_rst_n = rn;
    mon_wr_en = wg; mon_rd_en = rg; mon_data_in = din;
    mon_status = {f_ack, f_udf, f_ovf, sz == 1, sz == 0,
                  sz == 7, sz == 8, 1'b0} ^ {flip[7:1], 1'b0};
    mon_data_out = flip[0] ? ~f_dout : f_dout;
    cmp = !r && !frozen && live && rn && (hi_prev >= 2);
    cc  = !r && !frozen && live && (hi_prev >= 1);
    map = {flip[7:1], flip[0] & prev_rdok};
    @(posedge clk);
    #1;
    if (!rn) begin
      q.delete();
      f_dout = '0; f_ack = 0; f_ovf = 0; f_udf = 0; prev_rdok = 0;
    end else begin
      wok = wg && (sz < 8);
      rok = rg && (sz > 0);
      f_ovf = wg && (sz == 8);
      f_udf = rg && (sz == 0);
      f_ack = wok;
      if (rok) f_dout = q.pop_front();
      if (wok) q.push_back(din);
      prev_rdok = rok;
    end
    if (r) begin
      clear_exp();
    end else if (!frozen) begin
      for (int i = 0; i < 2; i++) begin
        mm = map & msk[i];
        e_cv[i] = cmp;
        e_cp[i] = cmp && (mm == 0);
        if (cmp) begin
          if (mm == 0) begin
            if (e_pass[i] < max_c[i]) e_pass[i]++;
          end else begin
            if (e_err[i] < max_c[i]) e_err[i]++;
            e_flags[i] |= mm;
            if (e_fvld[i] == 0) begin
              e_fvld[i] = 1;
              e_fmap[i] = mm;
              e_fcyc[i] = (cyc < max_c[i]) ? cyc : max_c[i];
            end
          end
        end
      end
      if (cc) cyc++;
      if (fin) frozen = 1;
      else if (live) hi_prev = rn ? hi_prev + 1 : 0;
      else if (en) live = 1;
    end
    check_all();
  endtask

  task automatic op(input logic wr, rd, input logic [15:0] d,
                    input logic [7:0] fl);
    step(0, 0, 0, 1, wr, rd, d, fl);
  endtask

  task automatic add(input logic wr, rd, input logic [15:0] d,
                     input logic [7:0] fl, input logic ep);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = d; v.flip = fl; v.exp_pass = ep;
    tbl.push_back(v);
  endtask

  initial begin
    logic [7:0] fl;
    logic rn, w, rd;

    for (int i = 0; i < 8; i++) add(1, 0, 16'(i + 1), 8'h00, 1);
    add(1, 0, 16'h0009, 8'h00, 1);
    add(0, 0, 16'h0000, 8'h20, 0);
    for (int i = 0; i < 8; i++) add(0, 1, 16'h0000, 8'h00, 1);
    add(0, 0, 16'h0000, 8'h00, 1);
    add(0, 1, 16'h0000, 8'h00, 1);
    add(0, 0, 16'h0000, 8'h00, 1);
    add(1, 1, 16'h00A5, 8'h00, 1);
    add(0, 0, 16'h0000, 8'h00, 1);
    add(0, 1, 16'h0000, 8'h00, 1);
    add(1, 0, 16'h0011, 8'h00, 1);
    add(1, 0, 16'h0022, 8'h00, 1);
    add(1, 0, 16'h0033, 8'h00, 1);
    for (int i = 0; i < 3; i++) add(0, 1, 16'h0000, 8'h00, 1);
    add(0, 0, 16'h0000, 8'h01, 0);
    add(0, 0, 16'h0000, 8'h01, 1);
    add(0, 0, 16'h0000, 8'h80, 0);

    f_dout = '0; f_ack = 0; f_ovf = 0; f_udf = 0; prev_rdok = 0;
    clear_exp();

    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) op(0, 0, 0, 0);
    chk("warm_valid", a_cv, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      op(tbl[i].wr, tbl[i].rd, tbl[i].din, tbl[i].flip);
      chk("tbl_valid", a_cv, 1);
      chk("tbl_pass", a_cp, tbl[i].exp_pass);
      if (i == 9) begin
        chk("ovf_err_cnt", a_ec, 1);
        chk("ovf_flags", a_fl, 8'h20);
        chk("ovf_first_map", a_fmap, 8'h20);
      end
      if (i == 17) chk("burst_pass_ge16", a_pc >= 16, 1);
    end
    chk("tbl_a_err", a_ec, 3);
    chk("tbl_a_flags", a_fl, 8'hA1);
    chk("tbl_b_err", b_ec, 2);
    chk("tbl_b_flags", b_fl, 8'hA0);
    chk("sat_b_pass", b_pc, 4'hF);

    for (int i = 0; i < 3; i++) op(1, 0, 16'h0100 + 16'(i), 0);
    step(0, 0, 0, 0, 1, 0, 16'h0BAD, 0);
    op(1, 0, 16'h0BAD, 0);
    op(0, 0, 0, 0);
    op(1, 0, 16'h0200, 0);
    op(1, 0, 16'h0201, 0);
    op(0, 1, 0, 0);
    op(0, 1, 0, 0);
    op(0, 0, 0, 0);
    chk("mrst_no_err", a_ec, 3);

    for (int i = 0; i < 400; i++) begin
      fl = 8'h00;
      if ($urandom_range(0, 15) == 0) fl[$urandom_range(0, 7)] = 1'b1;
      rn = ($urandom_range(0, 59) != 0);
      w  = ($urandom_range(0, 99) < 55);
      rd = ($urandom_range(0, 99) < 50);
      step(0, 0, 0, rn, w, rd, 16'($urandom), fl);
    end

    step(0, 0, 1, 1, 0, 1, 0, 0);
    chk("fin_report", a_rv, 1);
    for (int i = 0; i < 5; i++) op(1, 1, 16'($urandom), 8'hFF);

    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_pass_cnt", a_pc, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    chk("idle_fin_report", b_rv, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
